cnn_mul_share_arb: RTL

//  Shares one unsigned 11x9->20 multiplier between NREQ requesters (conv/dense address and scale units).

---
 rtl/cnn_mul_pkg.sv | 30 +++
 rtl/cnn_mul_core_11x9.sv | 19 +
 rtl/cnn_mul_share_arb.sv | 118 +++++++++++
 3 files changed

// File: rtl/cnn_mul_pkg.sv
// Purpose: shared widths and the round-robin pick helper for the multiplier-sharing block.
// Latency: n/a (declarations and a combinational function only).
// Backpressure: n/a.
package cnn_mul_pkg;

    localparam int MUL_AW    = 11;
    localparam int MUL_BW    = 9;
    localparam int MUL_PW    = 20;
    localparam int RR_MAXREQ = 8;

    // Returns {found, idx}: first set bit of valid[n-1:0] scanning ptr, ptr+1, ... mod n.
    // Scanning from the far end downwards lets the closest candidate overwrite the others.
    function automatic logic [3:0] rr_pick(input logic [RR_MAXREQ-1:0] valid,
                                           input logic [2:0]           ptr,
                                           input int                   n);
        logic [3:0] r;
        int         idx;
        r = '0;
        for (int k = RR_MAXREQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (valid[idx[2:0]]) begin
                    r = {1'b1, idx[2:0]};
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cnn_mul_core_11x9.sv
// Purpose: unsigned a*b multiplier, full-width product, maps onto a single DSP slice.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the surrounding pipeline decides when the product is captured.
module cnn_mul_core_11x9
    import cnn_mul_pkg::*;
#(
    parameter int AW = MUL_AW,
    parameter int BW = MUL_BW,
    parameter int PW = AW + BW
) (
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    output logic [PW-1:0] p
);

    // Both operands are widened first so the product keeps every bit.
    assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/cnn_mul_share_arb.sv
// Purpose: round-robin share of one multiplier between NREQ requesters, in-order tagged responses.
// Latency: 2 cycles accept-to-rsp_valid; one product per cycle while rsp_ready stays high.
// Backpressure: rsp_valid & !rsp_ready freezes the output stage; an empty operand stage still absorbs one request.
module cnn_mul_share_arb
    import cnn_mul_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int AW   = MUL_AW,
    parameter int BW   = MUL_BW,
    parameter int PW   = AW + BW
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_a,
    input  logic [NREQ*BW-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    output logic [PW-1:0]      rsp_p,
    output logic [IDW-1:0]     rsp_id,
    input  logic               rsp_ready,
    output logic [31:0]        done_cnt
);

    typedef struct packed {
        logic [AW-1:0]  a;
        logic [BW-1:0]  b;
        logic [IDW-1:0] id;
    } s1_t;

    s1_t                  s1_q;
    s1_t                  s1_d;
    logic                 s1_v;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       rr_nxt;
    logic [IDW-1:0]       gidx;
    logic [RR_MAXREQ-1:0] vpad;
    logic [2:0]           ppad;
    logic [3:0]           pick;
    logic                 adv1;
    logic                 adv2;
    logic                 accept;
    logic [PW-1:0]        prod;

    // Arbitration, stall chain and the operand bundle of the granted requester.
    always_comb begin
        vpad              = '0;
        vpad[NREQ-1:0]    = req_valid;
        ppad              = '0;
        ppad[IDW-1:0]     = rr_ptr;
        pick              = rr_pick(vpad, ppad, NREQ);
        gidx              = IDW'(pick[2:0]);

        adv2   = !rsp_valid | rsp_ready;
        adv1   = !s1_v | adv2;
        accept = pick[3] & adv1 & !ap_rst;

        req_ready = '0;
        if (accept) begin
            req_ready[gidx] = 1'b1;
        end

        s1_d.a  = req_a[gidx*AW +: AW];
        s1_d.b  = req_b[gidx*BW +: BW];
        s1_d.id = gidx;

        rr_nxt = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end

    // Operand stage and round-robin pointer; the pointer only moves past a served requester.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s1_q   <= '0;
            s1_v   <= 1'b0;
            rr_ptr <= '0;
        end else if (accept) begin
            s1_q   <= s1_d;
            s1_v   <= 1'b1;
            rr_ptr <= rr_nxt;
        end else if (adv1) begin
            s1_v   <= 1'b0;
        end
    end

    cnn_mul_core_11x9 #(
        .AW (AW),
        .BW (BW),
        .PW (PW)
    ) u_mul (
        .a (s1_q.a),
        .b (s1_q.b),
        .p (prod)
    );

    // Product stage; data and id stay frozen while the consumer is stalling.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rsp_valid <= 1'b0;
            rsp_p     <= '0;
            rsp_id    <= '0;
        end else if (adv2) begin
            rsp_valid <= s1_v;
            rsp_p     <= prod;
            rsp_id    <= s1_q.id;
        end
    end

    // Completed-response counter, free-running wrap.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            done_cnt <= '0;
        end else if (rsp_valid && rsp_ready) begin
            done_cnt <= done_cnt + 32'd1;
        end
    end

endmodule
